// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StData = 3'd2,
    StCsum = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } loader_state_e;

  localparam int unsigned BytesPerWord = 4;

  // Lane index of the final byte in a little-endian word.
  function automatic logic is_last_lane(logic [1:0] idx);
    return idx == 2'(BytesPerWord - 1);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes into a 32-bit little-endian word; the word output already reflects the
// byte being shifted in, so the full word is usable in the same cycle as word_complete.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  byte_idx,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    if (shift_en) begin
      word[{byte_idx, 3'b000} +: 8] = byte_in;
    end
  end

  assign word_complete = shift_en && is_last_lane(byte_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (shift_en) begin
      word_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: header word count, LE data words written to IMEM, XOR checksum.
// The core is held in reset until a load completes with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned IMEM_DEPTH     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e state_q, state_d;

  logic [1:0]        byte_idx_q;
  logic [7:0]        csum_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_inc;
  logic [ADDR_W:0]   n_q;
  logic [TmoW-1:0]   tmo_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_n_q;

  logic        accept;
  logic        pack_en;
  logic [31:0] word;
  logic        word_complete;
  logic        hdr_ok;
  logic        last_word;
  logic        timeout_hit;
  logic        hdr_enter;

  assign accept    = s_valid && s_ready;
  assign pack_en   = accept && ((state_q == StHdr) || (state_q == StData));
  assign hdr_ok    = (word != 32'd0) && (word <= 32'(IMEM_DEPTH));
  assign words_inc = words_q + (ADDR_W + 1)'(1);
  assign last_word = words_inc == n_q;
  assign hdr_enter = (state_d == StHdr) && (state_q != StHdr);

  // Idle cycles are only counted while a transfer is in flight.
  assign timeout_hit = busy && !accept && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  imem_loader_byte_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .byte_idx      (byte_idx_q),
    .shift_en      (pack_en),
    .byte_in       (s_data),
    .word          (word),
    .word_complete (word_complete)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StHdr;
      end
      StHdr: begin
        if (word_complete)    state_d = hdr_ok ? StData : StErr;
        else if (timeout_hit) state_d = StErr;
      end
      StData: begin
        if (word_complete && last_word) state_d = StCsum;
        else if (timeout_hit)           state_d = StErr;
      end
      StCsum: begin
        if (accept)           state_d = (s_data == csum_q) ? StDone : StErr;
        else if (timeout_hit) state_d = StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    unique case (state_q)
      StHdr, StData, StCsum: busy  = 1'b1;
      StDone:                done  = 1'b1;
      StErr:                 error = 1'b1;
      default:               ;
    endcase
    s_ready = busy;
  end

  // Datapath: byte index, checksum, counters and IMEM write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx_q   <= '0;
      csum_q       <= '0;
      words_q      <= '0;
      n_q          <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      core_rst_n_q <= state_d == StDone;
      if (hdr_enter) begin
        byte_idx_q <= '0;
        csum_q     <= '0;
        words_q    <= '0;
        tmo_q      <= '0;
      end else begin
        if (busy) begin
          tmo_q <= accept ? '0 : tmo_q + TmoW'(1);
        end
        if (pack_en) begin
          byte_idx_q <= byte_idx_q + 2'd1;
        end
        if (pack_en && (state_q == StData)) begin
          csum_q <= csum_q ^ s_data;
        end
        // hdr_ok bounds N to IMEM_DEPTH, so the truncated copy is exact whenever it is used.
        if (word_complete && (state_q == StHdr)) begin
          n_q <= word[ADDR_W:0];
        end
        if (word_complete && (state_q == StData)) begin
          we_q    <= 1'b1;
          addr_q  <= words_q[ADDR_W-1:0];
          wdata_q <= word;
          words_q <= words_inc;
        end
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;
  assign core_rst_n   = core_rst_n_q;

endmodule
